// File: rtl/clock_core.sv
// clock_core: 1 Hz timekeeping with time/alarm setting via two keys and a ring request.
// Alarm registers, match logic and ring counter are built only when CLOCK_ALARM_EN is defined.
module clock_core #(
    parameter int CLK_DIV   = 50_000_000,
    parameter int BELL_SECS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] state_mode,
    input  logic       key_sel,
    input  logic       key_inc,
    output logic [7:0] hour_time,
    output logic [7:0] minute_time,
    output logic [7:0] second_time,
    output logic [3:0] week_day,
    output logic [7:0] alarm_hour_time,
    output logic [7:0] alarm_minute_time,
    output logic [7:0] alarm_second_time,
    output logic       bell_en,
    output logic [1:0] sel_field
);

    localparam int              CNT_W   = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    function automatic logic [7:0] inc_wrap(input logic [7:0] val, input logic [7:0] last);
        return (val >= last) ? 8'd0 : val + 8'd1;
    endfunction

    logic             mode_set_time;
    logic             mode_set_alarm;
    logic             tick;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       mode_q;
    logic [1:0]       sel_q, sel_d;
    logic [7:0]       hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic [3:0]       wday_q, wday_d;

    assign mode_set_time = (state_mode == 4'd1);
`ifdef CLOCK_ALARM_EN
    assign mode_set_alarm = (state_mode == 4'd3);
`else
    assign mode_set_alarm = 1'b0;
`endif

    // The divider is frozen at 0 while the user is setting the time.
    assign tick = !mode_set_time && (cnt_q == CNT_MAX);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        cnt_d = cnt_q + CNT_W'(1);
        if (mode_set_time || tick) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        sel_d = sel_q;
        if (state_mode != mode_q) begin
            sel_d = 2'd0;
        end else if (key_sel) begin
            if (mode_set_time) begin
                sel_d = sel_q + 2'd1;
            end else if (mode_set_alarm) begin
                sel_d = (sel_q >= 2'd2) ? 2'd0 : sel_q + 2'd1;
            end
        end
    end

    always_comb begin
        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        wday_d = wday_q;
        if (tick) begin
            if (sec_q >= 8'd59) begin
                sec_d = 8'd0;
                if (min_q >= 8'd59) begin
                    min_d = 8'd0;
                    if (hour_q >= 8'd23) begin
                        hour_d = 8'd0;
                        wday_d = (wday_q >= 4'd7) ? 4'd1 : wday_q + 4'd1;
                    end else begin
                        hour_d = hour_q + 8'd1;
                    end
                end else begin
                    min_d = min_q + 8'd1;
                end
            end else begin
                sec_d = sec_q + 8'd1;
            end
        end else if (mode_set_time && key_inc) begin
            // Setting wraps each field on its own; no carry into the next field.
            case (sel_q)
                2'd0:    hour_d = inc_wrap(hour_q, 8'd23);
                2'd1:    min_d  = inc_wrap(min_q, 8'd59);
                2'd2:    sec_d  = 8'd0;
                default: wday_d = (wday_q >= 4'd7) ? 4'd1 : wday_q + 4'd1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            cnt_q  <= '0;
            mode_q <= 4'd0;
            sel_q  <= 2'd0;
            hour_q <= 8'd0;
            min_q  <= 8'd0;
            sec_q  <= 8'd0;
            wday_q <= 4'd1;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= state_mode;
            sel_q  <= sel_d;
            hour_q <= hour_d;
            min_q  <= min_d;
            sec_q  <= sec_d;
            wday_q <= wday_d;
        end
    end

    assign hour_time   = hour_q;
    assign minute_time = min_q;
    assign second_time = sec_q;
    assign week_day    = wday_q;
    assign sel_field   = sel_q;

`ifdef CLOCK_ALARM_EN
    localparam int               RING_W    = (BELL_SECS > 1) ? $clog2(BELL_SECS) : 1;
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(BELL_SECS - 1);

    logic [7:0]        al_hour_q, al_hour_d, al_min_q, al_min_d, al_sec_q, al_sec_d;
    logic              match_q, match_d;
    logic              bell_q, bell_d;
    logic [RING_W-1:0] ring_q, ring_d;
    logic              cancel;
    logic              trigger;

    assign cancel  = bell_q && (key_sel || key_inc);
    assign trigger = tick && ({hour_d, min_d, sec_d} == {al_hour_q, al_min_q, al_sec_q});

    always_comb begin
        al_hour_d = al_hour_q;
        al_min_d  = al_min_q;
        al_sec_d  = al_sec_q;
        if (mode_set_alarm && key_inc) begin
            case (sel_q)
                2'd0:    al_hour_d = inc_wrap(al_hour_q, 8'd23);
                2'd1:    al_min_d  = inc_wrap(al_min_q, 8'd59);
                default: al_sec_d  = inc_wrap(al_sec_q, 8'd59);
            endcase
        end
    end

    // match_q delays the ring start so bell_en rises the cycle after the matching time is shown.
    always_comb begin
        match_d = trigger && !cancel;
        bell_d  = bell_q;
        ring_d  = ring_q;
        if (cancel) begin
            bell_d = 1'b0;
            ring_d = '0;
        end else if (match_q) begin
            bell_d = 1'b1;
            ring_d = '0;
        end else if (bell_q && tick) begin
            if (ring_q == RING_LAST) begin
                bell_d = 1'b0;
                ring_d = '0;
            end else begin
                ring_d = ring_q + RING_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            al_hour_q <= 8'd0;
            al_min_q  <= 8'd0;
            al_sec_q  <= 8'd0;
            match_q   <= 1'b0;
            bell_q    <= 1'b0;
            ring_q    <= '0;
        end else begin
            al_hour_q <= al_hour_d;
            al_min_q  <= al_min_d;
            al_sec_q  <= al_sec_d;
            match_q   <= match_d;
            bell_q    <= bell_d;
            ring_q    <= ring_d;
        end
    end

    assign alarm_hour_time   = al_hour_q;
    assign alarm_minute_time = al_min_q;
    assign alarm_second_time = al_sec_q;
    assign bell_en           = bell_q;
`else
    assign alarm_hour_time   = 8'd0;
    assign alarm_minute_time = 8'd0;
    assign alarm_second_time = 8'd0;
    assign bell_en           = 1'b0;
`endif

endmodule
